// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data memory: access sizes,
// FSM state encoding, the latched request record and the alignment rule.
`timescale 1ns/1ps
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } dmem_state_t;

  // Request fields captured on accept; control is {u, size}.
  typedef struct packed {
    logic        we;
    logic [31:0] wd;
    logic [2:0]  control;
  } dmem_req_t;

  // Size 1x is a word access regardless of the low size bit.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a_lo);
    logic mis;
    mis = 1'b0;
    if (size[1])
      mis = (a_lo != 2'b00);
    else if (size == SZ_HALF)
      mis = a_lo[0];
    return mis;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering: write enables and replicated store data for sb/sh/sw,
// lane extraction plus sign/zero extension for loads. Purely combinational.
`timescale 1ns/1ps
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        u,
  input  logic [1:0]  a_lo,
  input  logic [31:0] wd,
  input  logic [31:0] memread,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = memread[7:0];
    case (a_lo)
      2'b00:   byte_sel = memread[7:0];
      2'b01:   byte_sel = memread[15:8];
      2'b10:   byte_sel = memread[23:16];
      default: byte_sel = memread[31:24];
    endcase
    half_sel = a_lo[1] ? memread[31:16] : memread[15:0];
  end

  // Store data is replicated across lanes so the enables alone pick the target.
  always_comb begin
    be    = 4'b0000;
    wdata = wd;
    rdata = 32'h0;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << a_lo;
        wdata = {4{wd[7:0]}};
        rdata = {{24{~u & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be    = a_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd[15:0]}};
        rdata = {{16{~u & half_sel[15]}}, half_sel};
      end
      default: begin
        be    = 4'b1111;
        wdata = wd;
        rdata = memread;
      end
    endcase
    if (is_misaligned(size, a_lo)) begin
      be    = 4'b0000;
      rdata = 32'h0;
    end
  end

endmodule

// File: rtl/dmem_hs.sv
// Handshaked word-organised data memory for the MEM stage: IDLE/BUSY/RESP
// FSM with programmable wait states, byte-lane stores and misalignment errors.
`timescale 1ns/1ps
module dmem_hs
  import dmem_pkg::*;
#(
  parameter int    DEPTH       = 64,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic [2:0]  Control,
  output logic        rsp_valid,
  output logic [31:0] rd,
  output logic        rsp_err,
  output dmem_state_t dbg_state
);

  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; rsp_valid is a one-cycle pulse with rd/rsp_err.

  dmem_state_t     state, state_next;
  logic [3:0]      cnt;
  dmem_req_t       req_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     rd_q;
  logic            err_q;
  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic            commit;
  logic            mis;
  logic [AW-1:0]   idx;
  logic [3:0]      be;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            unused_addr_hi;

  // Address bits above the RAM are ignored, so accesses wrap modulo DEPTH*4.
  assign unused_addr_hi = ^a[31:AW+2];

  assign idx    = addr_q[AW+1:2];
  assign accept = (state == IDLE) && req_valid;
  assign commit = (state == BUSY) && (cnt == 4'd0);
  assign mis    = is_misaligned(req_q.control[1:0], addr_q[1:0]);

  dmem_align u_align (
    .size    (req_q.control[1:0]),
    .u       (req_q.control[2]),
    .a_lo    (addr_q[1:0]),
    .wd      (req_q.wd),
    .memread (mem[idx]),
    .be      (be),
    .wdata   (wdata),
    .rdata   (rdata)
  );

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = BUSY;
      end
      BUSY: begin
        if (cnt == 4'd0) state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rd_q  <= 32'h0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        req_q.we      <= we;
        req_q.wd      <= wd;
        req_q.control <= Control;
        addr_q        <= a[AW+1:0];
        cnt           <= WS;
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rd_q  <= req_q.we ? 32'h0 : rdata;
        err_q <= mis;
      end else if (state == RESP) begin
        rd_q  <= 32'h0;
        err_q <= 1'b0;
      end
    end
  end

  // RAM is never reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && commit && req_q.we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rd        = rd_q;
  assign rsp_err   = err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_hs.sv
// Directed bench for dmem_hs: a W=0 instance driven from a vector table and a
// W=3 instance exercising latency, held req_valid, aliasing and reset abort.
`timescale 1ns/1ps
module tb_dmem_hs;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        we        [2];
  logic [31:0] a         [2];
  logic [31:0] wd        [2];
  logic [2:0]  ctrl      [2];
  logic        rsp_valid [2];
  logic [31:0] rd        [2];
  logic        rsp_err   [2];
  dmem_state_t dbg_state [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_hs #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .we(we[0]), .a(a[0]), .wd(wd[0]), .Control(ctrl[0]), .rsp_valid(rsp_valid[0]),
    .rd(rd[0]), .rsp_err(rsp_err[0]), .dbg_state(dbg_state[0])
  );

  dmem_hs #(.DEPTH(64), .WAIT_STATES(3)) dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .we(we[1]), .a(a[1]), .wd(wd[1]), .Control(ctrl[1]), .rsp_valid(rsp_valid[1]),
    .rd(rd[1]), .rsp_err(rsp_err[1]), .dbg_state(dbg_state[1])
  );

  localparam logic [2:0] C_LB = 3'b000, C_LH = 3'b001, C_LW = 3'b010, C_LW11 = 3'b011;
  localparam logic [2:0] C_LBU = 3'b100, C_LHU = 3'b101, C_LWU = 3'b110;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  c;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the #1-after-edge phase with the instance idle.
  task automatic do_req(input int w, input logic we_i, input logic [31:0] a_i,
                        input logic [31:0] wd_i, input logic [2:0] c_i, input int exp_lat,
                        output logic [31:0] rd_o, output logic err_o);
    int lat;
    check("ready_idle", 32'(req_ready[w]), 32'd1);
    req_valid[w] = 1'b1; we[w] = we_i; a[w] = a_i; wd[w] = wd_i; ctrl[w] = c_i;
    step();
    req_valid[w] = 1'b0; we[w] = 1'b0; a[w] = 32'h0; wd[w] = 32'h0; ctrl[w] = 3'b0;
    check("ready_busy", 32'(req_ready[w]), 32'd0);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (rsp_valid[w]) begin
        lat = c - 1;
        break;
      end
      step();
    end
    check("latency", 32'(lat), 32'(exp_lat));
    rd_o  = rd[w];
    err_o = rsp_err[w];
    check("ready_resp", 32'(req_ready[w]), 32'd0);
    step();
    check("rsp_pulse", 32'(rsp_valid[w]), 32'd0);
    check("ready_back", 32'(req_ready[w]), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    logic        seen;
    logic        rv_tr [16];
    logic        rr_tr [16];
    logic [31:0] rd_tr [16];

    vecs[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, C_LW,  32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h08, 32'h0,        C_LW,  32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h00, 32'h11223344, C_LW,  32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h02, 32'h123456AA, C_LB,  32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h00, 32'h0,        C_LW,  32'h11AA3344, 1'b0};
    vecs[5]  = '{1'b0, 32'h02, 32'h0,        C_LB,  32'hFFFFFFAA, 1'b0};
    vecs[6]  = '{1'b0, 32'h02, 32'h0,        C_LBU, 32'h000000AA, 1'b0};
    vecs[7]  = '{1'b1, 32'h04, 32'h0,        C_LW,  32'h0,        1'b0};
    vecs[8]  = '{1'b1, 32'h06, 32'hFFFF8001, C_LH,  32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h04, 32'h0,        C_LW,  32'h80010000, 1'b0};
    vecs[10] = '{1'b0, 32'h06, 32'h0,        C_LH,  32'hFFFF8001, 1'b0};
    vecs[11] = '{1'b0, 32'h06, 32'h0,        C_LHU, 32'h00008001, 1'b0};
    vecs[12] = '{1'b1, 32'h05, 32'hFFFFFFFF, C_LW,  32'h0,        1'b1};
    vecs[13] = '{1'b0, 32'h04, 32'h0,        C_LW,  32'h80010000, 1'b0};
    vecs[14] = '{1'b0, 32'h03, 32'h0,        C_LH,  32'h0,        1'b1};
    vecs[15] = '{1'b0, 32'h03, 32'h0,        C_LB,  32'h00000011, 1'b0};
    vecs[16] = '{1'b0, 32'h02, 32'h0,        C_LH,  32'h000011AA, 1'b0};
    vecs[17] = '{1'b0, 32'h02, 32'h0,        C_LW11, 32'h0,       1'b1};
    vecs[18] = '{1'b1, 32'h01, 32'hBEEF,     C_LH,  32'h0,        1'b1};
    vecs[19] = '{1'b0, 32'h00, 32'h0,        C_LW,  32'h11AA3344, 1'b0};
    vecs[20] = '{1'b0, 32'h07, 32'h0,        C_LBU, 32'h00000080, 1'b0};

    for (int w = 0; w < 2; w++) begin
      reset[w] = 1'b1; req_valid[w] = 1'b0; we[w] = 1'b0;
      a[w] = 32'h0; wd[w] = 32'h0; ctrl[w] = 3'b0;
    end
    repeat (3) step();
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      check("rst_ready", 32'(req_ready[w]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[w]), 32'd0);
      check("rst_rd", rd[w], 32'h0);
      check("rst_err", 32'(rsp_err[w]), 32'd0);
    end

    // Table-driven sequence on the zero-wait-state instance.
    for (int i = 0; i < NV; i++) begin
      do_req(0, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].c, 1, r, e);
      check($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
    end
    do_req(0, 1'b0, 32'h08, 32'h0, C_LWU, 1, r, e);
    check("lw_u_ignored", r, 32'hDEADBEEF);

    // Three wait states: latency 4, and 0x100 aliases word 0.
    do_req(1, 1'b1, 32'h100, 32'hCAFEF00D, C_LW, 4, r, e);
    check("w3_sw_rd", r, 32'h0);
    do_req(1, 1'b0, 32'h000, 32'h0, C_LW, 4, r, e);
    check("w3_alias_rd", r, 32'hCAFEF00D);

    // req_valid held high: second accept in the IDLE cycle following RESP.
    req_valid[1] = 1'b1; we[1] = 1'b0; a[1] = 32'h0; ctrl[1] = C_LW;
    for (int p = 1; p < 16; p++) begin
      step();
      rv_tr[p] = rsp_valid[1];
      rr_tr[p] = req_ready[1];
      rd_tr[p] = rd[1];
      if (p == 7) req_valid[1] = 1'b0;
    end
    for (int p = 1; p < 16; p++) begin
      check($sformatf("hold_rsp_p%0d", p), 32'(rv_tr[p]), 32'((p == 5) || (p == 11)));
      check($sformatf("hold_rdy_p%0d", p), 32'(rr_tr[p]), 32'((p == 6) || (p >= 12)));
    end
    check("hold_rd1", rd_tr[5], 32'hCAFEF00D);
    check("hold_rd2", rd_tr[11], 32'hCAFEF00D);

    // Reset during BUSY aborts the store.
    do_req(1, 1'b1, 32'h0, 32'h0, C_LW, 4, r, e);
    req_valid[1] = 1'b1; we[1] = 1'b1; a[1] = 32'h0; wd[1] = 32'h12345678; ctrl[1] = C_LW;
    step();
    req_valid[1] = 1'b0; we[1] = 1'b0;
    check("abort_busy", 32'(req_ready[1]), 32'd0);
    reset[1] = 1'b1;
    step();
    reset[1] = 1'b0;
    check("abort_ready", 32'(req_ready[1]), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    check("abort_rd", rd[1], 32'h0);
    check("abort_err", 32'(rsp_err[1]), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (rsp_valid[1]) seen = 1'b1;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    do_req(1, 1'b0, 32'h0, 32'h0, C_LW, 4, r, e);
    check("abort_no_write", r, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
